// File: rtl/onehot_priority_mux.sv
// ============================================================================
// Module   : onehot_priority_mux
// Purpose  : Lowest-index priority arbiter fused with a one-hot AND-OR data
//            mux. Optional sticky winner hold is compiled in when the macro
//            ONEHOT_PRIORITY_STICKY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_priority_mux #(
   parameter int N_INPUTS = 2,
   parameter int W_DATA   = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         canchange,
   input  logic [N_INPUTS-1:0]          req,
   input  logic [N_INPUTS*W_DATA-1:0]   din,
   output logic [N_INPUTS-1:0]          gnt,
   output logic [N_INPUTS-1:0]          gnt_q,
   output logic                         any,
   output logic [W_DATA-1:0]            dout
);

   logic [N_INPUTS-1:0] w_prio;
   logic [N_INPUTS-1:0] w_gnt;
   logic [N_INPUTS-1:0] r_gnt_q;
   logic [W_DATA-1:0]   w_dout;

   // Two's-complement trick isolates the lowest set bit of req.
   assign w_prio = req & (~req + {{(N_INPUTS-1){1'b0}}, 1'b1});

`ifdef ONEHOT_PRIORITY_STICKY_EN
   logic w_hold;

   // r_gnt_q is always one-hot or zero, so holding it keeps gnt one-hot.
   assign w_hold = canchange & (|(r_gnt_q & req));
   assign w_gnt  = w_hold ? r_gnt_q : w_prio;
`else
   logic w_unused_canchange;

   assign w_unused_canchange = canchange;
   assign w_gnt              = w_prio;
`endif

   always_comb begin
      w_dout = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         w_dout = w_dout | (din[i*W_DATA +: W_DATA] & {W_DATA{w_gnt[i]}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt_q <= '0;
      end else begin
         r_gnt_q <= w_gnt;
      end
   end

   assign gnt   = w_gnt;
   assign gnt_q = r_gnt_q;
   assign any   = |req;
   assign dout  = w_dout;

endmodule

`default_nettype wire

// File: tb/tb_onehot_priority_mux.sv
// ============================================================================
// Module   : tb_onehot_priority_mux
// Purpose  : Directed self-checking bench for onehot_priority_mux (N=4, N=2,
//            N=3 instances); sticky expectations follow ONEHOT_PRIORITY_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_priority_mux;

   logic        clk;
   logic        rst_n;
   logic        canchange;

   logic [3:0]   req4;
   logic [127:0] din4;
   logic [3:0]   gnt4, gnt_q4;
   logic         any4;
   logic [31:0]  dout4;

   logic [1:0]   req2;
   logic [63:0]  din2;
   logic [1:0]   gnt2, gnt_q2;
   logic         any2;
   logic [31:0]  dout2;

   logic [2:0]   req3;
   logic [47:0]  din3;
   logic [2:0]   gnt3, gnt_q3;
   logic         any3;
   logic [15:0]  dout3;

   int n_assert;
   int n_fail;

   logic [2:0]  exp_gnt3 [8];
   logic [15:0] exp_dout3 [8];

   onehot_priority_mux #(.N_INPUTS(4), .W_DATA(32)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .canchange(canchange), .req(req4), .din(din4),
      .gnt(gnt4), .gnt_q(gnt_q4), .any(any4), .dout(dout4)
   );

   onehot_priority_mux #(.N_INPUTS(2), .W_DATA(32)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .canchange(canchange), .req(req2), .din(din2),
      .gnt(gnt2), .gnt_q(gnt_q2), .any(any2), .dout(dout2)
   );

   onehot_priority_mux #(.N_INPUTS(3), .W_DATA(16)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .canchange(canchange), .req(req3), .din(din3),
      .gnt(gnt3), .gnt_q(gnt_q3), .any(any3), .dout(dout3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      canchange = 1'b0;
      req4      = 4'b0000;
      req2      = 2'b00;
      req3      = 3'b000;
      din4      = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
      din2      = {32'hDEADBEEF, 32'h12345678};
      din3      = {16'hC3C3, 16'hB2B2, 16'hA1A1};

      exp_gnt3  = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001};
      exp_dout3 = '{16'h0000, 16'hA1A1, 16'hB2B2, 16'hA1A1,
                    16'hC3C3, 16'hA1A1, 16'hB2B2, 16'hA1A1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt_q4", 32'(gnt_q4), 32'h0);
      check("reset_gnt_q2", 32'(gnt_q2), 32'h0);
      check("reset_any4",   32'(any4),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Strict priority, N=4
      req4 = 4'b1010; #1;
      check("prio_1010_gnt",  32'(gnt4), 32'h2);
      check("prio_1010_dout", dout4,     32'h11111111);
      check("prio_1010_any",  32'(any4), 32'h1);
      req4 = 4'b1000; #1;
      check("prio_1000_gnt",  32'(gnt4), 32'h8);
      check("prio_1000_dout", dout4,     32'h33333333);
      req4 = 4'b0000; #1;
      check("prio_0000_gnt",  32'(gnt4), 32'h0);
      check("prio_0000_dout", dout4,     32'h0);
      check("prio_0000_any",  32'(any4), 32'h0);

      // Mux data, N=2
      req2 = 2'b11; #1;
      check("mux2_11_dout", dout2,     32'h12345678);
      check("mux2_11_gnt",  32'(gnt2), 32'h1);
      req2 = 2'b10; #1;
      check("mux2_10_dout", dout2,     32'hDEADBEEF);
      check("mux2_10_gnt",  32'(gnt2), 32'h2);

      // Registered grant
      @(negedge clk);
      req4 = 4'b0100;
      @(posedge clk); #1;
      check("gnt_q_0100", 32'(gnt_q4), 32'h4);
      req4 = 4'b0001;
      @(posedge clk); #1;
      check("gnt_q_0001", 32'(gnt_q4), 32'h1);

      // Asynchronous reset mid-cycle
      req4 = 4'b0010;
      @(posedge clk); #1;
      check("pre_reset_gnt_q", 32'(gnt_q4), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_gnt_q", 32'(gnt_q4), 32'h0);
      check("reset_comb_gnt",    32'(gnt4),   32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_load", 32'(gnt_q4), 32'h2);

      // Sticky sequence, canchange = 1
      canchange = 1'b1;
      @(negedge clk);
      req4 = 4'b0100;
      @(posedge clk); #1;
      check("sticky_prime_q", 32'(gnt_q4), 32'h4);
      req4 = 4'b0101; #1;
`ifdef ONEHOT_PRIORITY_STICKY_EN
      check("sticky_hold_gnt", 32'(gnt4), 32'h4);
`else
      check("sticky_hold_gnt", 32'(gnt4), 32'h1);
`endif
      @(posedge clk); #1;
`ifdef ONEHOT_PRIORITY_STICKY_EN
      check("sticky_hold_gnt2", 32'(gnt4), 32'h4);
`else
      check("sticky_hold_gnt2", 32'(gnt4), 32'h1);
`endif
      req4 = 4'b0001; #1;
      check("sticky_release_gnt", 32'(gnt4), 32'h1);

      // Same sequence with canchange = 0
      canchange = 1'b0;
      @(negedge clk);
      req4 = 4'b0100;
      @(posedge clk); #1;
      check("nosticky_prime_q", 32'(gnt_q4), 32'h4);
      req4 = 4'b0101; #1;
      check("nosticky_gnt", 32'(gnt4), 32'h1);

      // Exhaustive N=3 sweep
      for (int r = 0; r < 8; r++) begin
         req3 = 3'(r); #1;
         check($sformatf("sweep_gnt_%0d", r),    32'(gnt3),  32'(exp_gnt3[r]));
         check($sformatf("sweep_dout_%0d", r),   32'(dout3), 32'(exp_dout3[r]));
         check($sformatf("sweep_onehot_%0d", r), 32'($onehot0(gnt3)), 32'h1);
         check($sformatf("sweep_any_%0d", r),    32'(any3),  32'(r != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
